// File: rtl/usb_rx_pkt_ctrl.sv
// USB receive packet controller: SYNC/PID decode, token/handshake/data sequencing and FIFO byte streaming.
// Build option: define RX_PID_CHECK_EN to reject PID bytes whose upper nibble is not the complement of the lower.
module usb_rx_pkt_ctrl #(
    parameter logic [7:0]  SYNC_BYTE      = 8'h80,
    parameter int unsigned TOKEN_BYTES    = 2,
    parameter int unsigned MAX_DATA_BYTES = 66,
    parameter int unsigned MIN_DATA_BYTES = 2,
    parameter int unsigned BUF_DEPTH      = 64,
    parameter int unsigned CNT_W          = $clog2(MAX_DATA_BYTES + 1),
    parameter int unsigned OCC_W          = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_edge,
    input  logic             eop,
    input  logic             byte_received,
    input  logic [7:0]       rcv_data,
    input  logic [OCC_W-1:0] buffer_occupancy,
    output logic             clear_byte_received,
    output logic             flush,
    output logic             store_rx_packet_data,
    output logic [7:0]       rx_packet_data,
    output logic [3:0]       rx_packet,
    output logic             rx_data_ready,
    output logic             rx_transfer_active,
    output logic             rx_error,
    output logic [CNT_W-1:0] rx_byte_count
);

    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(MAX_DATA_BYTES);
    localparam logic [CNT_W-1:0] CNT_MIN      = CNT_W'(MIN_DATA_BYTES);
    localparam logic [CNT_W-1:0] CNT_TOK_LAST = CNT_W'(TOKEN_BYTES - 1);
    localparam logic [OCC_W-1:0] OCC_FULL     = OCC_W'(BUF_DEPTH);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_HS,
        ST_TOKEN,
        ST_TOK_END,
        ST_FLUSH,
        ST_DATA,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             clear_nxt;
    logic             flush_nxt;
    logic             store_nxt;
    logic [7:0]       data_nxt;
    logic [3:0]       pid_nxt;
    logic             ready_nxt;
    logic             active_nxt;
    logic             error_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] count_inc_c;
    logic             byte_seen_c;
    logic             pid_ok_c;

    // A byte stays asserted until the ack is seen, so ignore it while our ack is still out.
    assign byte_seen_c = byte_received & ~clear_byte_received;
    assign count_inc_c = (rx_byte_count == CNT_MAX) ? CNT_MAX : rx_byte_count + CNT_W'(1);

`ifdef RX_PID_CHECK_EN
    assign pid_ok_c = (rcv_data[7:4] == ~rcv_data[3:0]);
`else
    assign pid_ok_c = 1'b1;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_nxt  = state;
        clear_nxt  = 1'b0;
        store_nxt  = 1'b0;
        data_nxt   = 8'h00;
        ready_nxt  = 1'b0;
        pid_nxt    = rx_packet;
        count_nxt  = rx_byte_count;
        error_nxt  = rx_error;
        flush_nxt  = 1'b0;
        active_nxt = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (d_edge) begin
                    state_nxt = ST_SYNC;
                    error_nxt = 1'b0;
                    count_nxt = '0;
                end
            end
            ST_SYNC: begin
                if (byte_seen_c) begin
                    clear_nxt = 1'b1;
                    state_nxt = (rcv_data == SYNC_BYTE) ? ST_PID : ST_ERROR;
                end else if (eop) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_PID: begin
                if (byte_seen_c) begin
                    clear_nxt = 1'b1;
                    pid_nxt   = rcv_data[3:0];
                    if (!pid_ok_c) begin
                        state_nxt = ST_ERROR;
                    end else begin
                        case (rcv_data[3:0])
                            PID_ACK, PID_NAK:     state_nxt = ST_HS;
                            PID_IN, PID_OUT:      state_nxt = ST_TOKEN;
                            PID_DATA0, PID_DATA1: state_nxt = ST_FLUSH;
                            default:              state_nxt = ST_ERROR;
                        endcase
                    end
                end else if (eop) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_HS: begin
                if (byte_seen_c) begin
                    clear_nxt = 1'b1;
                    state_nxt = ST_ERROR;
                end else if (eop) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_TOKEN: begin
                if (byte_seen_c) begin
                    clear_nxt = 1'b1;
                    store_nxt = 1'b1;
                    data_nxt  = rcv_data;
                    count_nxt = count_inc_c;
                    if (rx_byte_count >= CNT_TOK_LAST) begin
                        state_nxt = ST_TOK_END;
                    end
                end else if (eop) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_TOK_END: begin
                if (byte_seen_c) begin
                    clear_nxt = 1'b1;
                    state_nxt = ST_ERROR;
                end else if (eop) begin
                    state_nxt = ST_DONE;
                    ready_nxt = 1'b1;
                end
            end
            ST_FLUSH: begin
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (byte_seen_c) begin
                    clear_nxt = 1'b1;
                    if ((rx_byte_count >= CNT_MAX) || (buffer_occupancy >= OCC_FULL)) begin
                        state_nxt = ST_ERROR;
                    end else begin
                        store_nxt = 1'b1;
                        data_nxt  = rcv_data;
                        count_nxt = count_inc_c;
                    end
                end else if (eop) begin
                    if (rx_byte_count >= CNT_MIN) begin
                        state_nxt = ST_DONE;
                        ready_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                if (byte_seen_c) begin
                    clear_nxt = 1'b1;
                end else if (eop) begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (state_nxt == ST_ERROR) begin
            error_nxt = 1'b1;
        end
        flush_nxt  = (state_nxt == ST_FLUSH);
        active_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state                <= ST_IDLE;
            clear_byte_received  <= 1'b0;
            flush                <= 1'b0;
            store_rx_packet_data <= 1'b0;
            rx_packet_data       <= 8'h00;
            rx_packet            <= 4'h0;
            rx_data_ready        <= 1'b0;
            rx_transfer_active   <= 1'b0;
            rx_error             <= 1'b0;
            rx_byte_count        <= '0;
        end else begin
            state                <= state_nxt;
            clear_byte_received  <= clear_nxt;
            flush                <= flush_nxt;
            store_rx_packet_data <= store_nxt;
            rx_packet_data       <= data_nxt;
            rx_packet            <= pid_nxt;
            rx_data_ready        <= ready_nxt;
            rx_transfer_active   <= active_nxt;
            rx_error             <= error_nxt;
            rx_byte_count        <= count_nxt;
        end
    end

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Self-checking bench for usb_rx_pkt_ctrl: table of whole-packet vectors plus hand-timed corner sequences.
module tb_usb_rx_pkt_ctrl;

    localparam int unsigned CNT_W = 7;
    localparam int unsigned OCC_W = 7;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             d_edge;
    logic             eop;
    logic             byte_received;
    logic [7:0]       rcv_data;
    logic [OCC_W-1:0] buffer_occupancy;
    logic             clear_byte_received;
    logic             flush;
    logic             store_rx_packet_data;
    logic [7:0]       rx_packet_data;
    logic [3:0]       rx_packet;
    logic             rx_data_ready;
    logic             rx_transfer_active;
    logic             rx_error;
    logic [CNT_W-1:0] rx_byte_count;

    usb_rx_pkt_ctrl dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .d_edge               (d_edge),
        .eop                  (eop),
        .byte_received        (byte_received),
        .rcv_data             (rcv_data),
        .buffer_occupancy     (buffer_occupancy),
        .clear_byte_received  (clear_byte_received),
        .flush                (flush),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .rx_packet            (rx_packet),
        .rx_data_ready        (rx_data_ready),
        .rx_transfer_active   (rx_transfer_active),
        .rx_error             (rx_error),
        .rx_byte_count        (rx_byte_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sync_b;
        int pid_b;
        int nbytes;
        int occ;
        int exp_stores;
        int exp_count;
        int exp_flush;
        int exp_ready;
        int exp_err;
        int exp_pid;
    } vec_t;

    vec_t vecs[16];

    int n_pass  = 0;
    int n_total = 0;

    int unsigned n_store_tot = 0;
    int unsigned n_flush_tot = 0;
    int unsigned n_ready_tot = 0;
    int unsigned n_bad_data  = 0;
    logic [7:0]  store_q[$];

    // Observe strobes on the falling edge, away from the registers' update edge
    always @(negedge clk) begin
        if (store_rx_packet_data) begin
            n_store_tot++;
            store_q.push_back(rx_packet_data);
        end else if (rx_packet_data != 8'h00) begin
            n_bad_data++;
        end
        if (flush) n_flush_tot++;
        if (rx_data_ready) n_ready_tot++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic pulse_dedge();
        @(posedge clk); #1;
        d_edge = 1'b1;
        @(posedge clk); #1;
        d_edge = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        rcv_data      = b;
        byte_received = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (clear_byte_received) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_total++;
            $display("FAIL ack_timeout: byte 0x%0h got no clear_byte_received within 8 cycles", b);
        end
        byte_received = 1'b0;
    endtask

    task automatic send_eop();
        @(posedge clk); #1;
        eop = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        eop = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_pkt(input vec_t v, input int idx);
        int unsigned s0, f0, r0, b0;
        int          dm;
        buffer_occupancy = OCC_W'(v.occ);
        s0 = n_store_tot;
        f0 = n_flush_tot;
        r0 = n_ready_tot;
        b0 = n_bad_data;
        pulse_dedge();
        send_byte(8'(v.sync_b));
        send_byte(8'(v.pid_b));
        for (int i = 0; i < v.nbytes; i++) send_byte(8'(i + 1));
        send_eop();
        dm = 0;
        for (int k = 0; k < int'(n_store_tot - s0); k++) begin
            if (store_q[s0 + k] !== 8'(k + 1)) dm++;
        end
        check($sformatf("pkt%0d stores", idx), int'(n_store_tot - s0), v.exp_stores);
        check($sformatf("pkt%0d byte_count", idx), int'(rx_byte_count), v.exp_count);
        check($sformatf("pkt%0d flushes", idx), int'(n_flush_tot - f0), v.exp_flush);
        check($sformatf("pkt%0d ready_pulses", idx), int'(n_ready_tot - r0), v.exp_ready);
        check($sformatf("pkt%0d rx_error", idx), int'(rx_error), v.exp_err);
        check($sformatf("pkt%0d rx_packet", idx), int'(rx_packet), v.exp_pid);
        check($sformatf("pkt%0d active_after_eop", idx), int'(rx_transfer_active), 0);
        check($sformatf("pkt%0d data_values", idx), dm, 0);
        check($sformatf("pkt%0d data_zero_when_idle", idx), int'(n_bad_data - b0), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned s0, r0;

        //              sync   pid   nb occ  st cnt fl rdy err pid
        vecs[0]  = '{8'h80, 8'hC3,  4,  0,  4,  4, 1, 1, 0, 4'h3};
        vecs[1]  = '{8'h80, 8'hE1,  2,  0,  2,  2, 0, 1, 0, 4'h1};
        vecs[2]  = '{8'h81, 8'hE1,  2,  0,  0,  0, 0, 0, 1, 4'h1};
        vecs[3]  = '{8'h80, 8'h4B, 67,  0, 66, 66, 1, 0, 1, 4'hB};
        vecs[4]  = '{8'h80, 8'hC3,  1, 64,  0,  0, 1, 0, 1, 4'h3};
        vecs[5]  = '{8'h80, 8'hD2,  0,  0,  0,  0, 0, 0, 0, 4'h2};
        vecs[6]  = '{8'h80, 8'h5A,  0,  0,  0,  0, 0, 0, 0, 4'hA};
        vecs[7]  = '{8'h80, 8'h69,  2,  0,  2,  2, 0, 1, 0, 4'h9};
        vecs[8]  = '{8'h80, 8'hC3,  1,  0,  1,  1, 1, 0, 1, 4'h3};
        vecs[9]  = '{8'h80, 8'hC3,  0,  0,  0,  0, 1, 0, 1, 4'h3};
        vecs[10] = '{8'h80, 8'hE1,  1,  0,  1,  1, 0, 0, 1, 4'h1};
        vecs[11] = '{8'h80, 8'hE1,  3,  0,  2,  2, 0, 0, 1, 4'h1};
        vecs[12] = '{8'h80, 8'hA5,  0,  0,  0,  0, 0, 0, 1, 4'h5};
        vecs[13] = '{8'h80, 8'hD2,  1,  0,  0,  0, 0, 0, 1, 4'h2};
        vecs[14] = '{8'h80, 8'hC3,  2,  0,  2,  2, 1, 1, 0, 4'h3};
        vecs[15] = '{8'h80, 8'hC3,  3, 63,  3,  3, 1, 1, 0, 4'h3};

        n_rst            = 1'b0;
        d_edge           = 1'b0;
        eop              = 1'b0;
        byte_received    = 1'b0;
        rcv_data         = 8'h00;
        buffer_occupancy = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset strobes", int'({clear_byte_received, flush, store_rx_packet_data, rx_data_ready}), 0);
        check("reset rx_packet_data", int'(rx_packet_data), 0);
        check("reset rx_packet", int'(rx_packet), 0);
        check("reset active/error", int'({rx_transfer_active, rx_error}), 0);
        check("reset byte_count", int'(rx_byte_count), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;

        for (int i = 0; i < 16; i++) run_pkt(vecs[i], i);

        // Ack and store land exactly one cycle after the byte is seen
        pulse_dedge();
        @(negedge clk);
        check("active after d_edge", int'(rx_transfer_active), 1);
        @(posedge clk); #1;
        rcv_data      = 8'h80;
        byte_received = 1'b1;
        @(negedge clk);
        check("ack not before edge", int'(clear_byte_received), 0);
        @(negedge clk);
        check("ack one cycle after", int'(clear_byte_received), 1);
        @(negedge clk);
        check("ack single cycle", int'(clear_byte_received), 0);
        byte_received = 1'b0;
        send_byte(8'hE1);
        @(posedge clk); #1;
        rcv_data      = 8'h11;
        byte_received = 1'b1;
        @(negedge clk);
        check("store not before edge", int'(store_rx_packet_data), 0);
        @(negedge clk);
        check("store data", int'({store_rx_packet_data, rx_packet_data}), 9'h111);
        check("count after first token byte", int'(rx_byte_count), 1);
        @(negedge clk);
        check("store single cycle", int'({store_rx_packet_data, rx_packet_data}), 0);
        byte_received = 1'b0;
        send_byte(8'h22);
        send_eop();
        check("token seq count", int'(rx_byte_count), 2);

        // Byte and eop together: byte stored first, eop completes the packet
        s0 = n_store_tot;
        r0 = n_ready_tot;
        pulse_dedge();
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'h01);
        @(posedge clk); #1;
        rcv_data      = 8'h02;
        byte_received = 1'b1;
        eop           = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("simul byte stored", int'({store_rx_packet_data, rx_packet_data}), 9'h102);
        byte_received = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        eop = 1'b0;
        @(negedge clk);
        check("simul stores", int'(n_store_tot - s0), 2);
        check("simul count", int'(rx_byte_count), 2);
        check("simul ready", int'(n_ready_tot - r0), 1);
        check("simul error", int'(rx_error), 0);

        // eop during SYNC errors; the next packet start clears the sticky error
        r0 = n_ready_tot;
        pulse_dedge();
        send_eop();
        check("eop in sync error", int'(rx_error), 1);
        check("eop in sync no ready", int'(n_ready_tot - r0), 0);
        pulse_dedge();
        @(negedge clk);
        check("error cleared on d_edge", int'(rx_error), 0);
        check("count cleared on d_edge", int'(rx_byte_count), 0);
        send_eop();

        // PID with mismatched complement nibble
        pulse_dedge();
        send_byte(8'h80);
        send_byte(8'h52);
        send_eop();
        check("pid 52 rx_packet", int'(rx_packet), 4'h2);
`ifdef RX_PID_CHECK_EN
        check("pid 52 rejected", int'(rx_error), 1);
`else
        check("pid 52 accepted as ACK", int'(rx_error), 0);
`endif

        // Asynchronous reset in the middle of a data packet
        pulse_dedge();
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'h01);
        @(posedge clk); #3;
        n_rst = 1'b0;
        #1;
        check("async reset active", int'(rx_transfer_active), 0);
        check("async reset count", int'(rx_byte_count), 0);
        check("async reset rx_packet", int'(rx_packet), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        run_pkt(vecs[0], 99);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
